// File: rtl/cmul_seq_ctrl.sv
// Sequential complex multiplier controller: time-shares one external W x W
// multiplier over four cycles to form (ar + j*ai) * (br + j*bi).
module cmul_seq_ctrl #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   ar,
  input  logic [W-1:0]   ai,
  input  logic [W-1:0]   br,
  input  logic [W-1:0]   bi,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W:0]   re,
  output logic [2*W:0]   im,
  output logic           busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M_AC = 3'd1,
    M_BD = 3'd2,
    M_AD = 3'd3,
    M_BC = 3'd4,
    DONE = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   ar_q, ar_d;
  logic [W-1:0]   ai_q, ai_d;
  logic [W-1:0]   br_q, br_d;
  logic [W-1:0]   bi_q, bi_d;
  logic [2*W:0]   re_q, re_d;
  logic [2*W:0]   im_q, im_d;
  logic [2*W:0]   prod_ext;

  // Products are unsigned; one extra bit gives re its sign and im its carry.
  assign prod_ext = {1'b0, mul_p};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ar_q    <= '0;
      ai_q    <= '0;
      br_q    <= '0;
      bi_q    <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      ai_q    <= ai_d;
      br_q    <= br_d;
      bi_q    <= bi_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    ai_d    = ai_q;
    br_d    = br_q;
    bi_d    = bi_q;
    re_d    = re_q;
    im_d    = im_q;
    mul_a   = '0;
    mul_b   = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ar_d    = ar;
          ai_d    = ai;
          br_d    = br;
          bi_d    = bi;
          state_d = M_AC;
        end
      end
      M_AC: begin
        mul_a   = ar_q;
        mul_b   = br_q;
        re_d    = prod_ext;
        state_d = M_BD;
      end
      M_BD: begin
        mul_a   = ai_q;
        mul_b   = bi_q;
        re_d    = re_q - prod_ext;
        state_d = M_AD;
      end
      M_AD: begin
        mul_a   = ar_q;
        mul_b   = bi_q;
        im_d    = prod_ext;
        state_d = M_BC;
      end
      M_BC: begin
        mul_a   = ai_q;
        mul_b   = br_q;
        im_d    = im_q + prod_ext;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign re        = re_q;
  assign im        = im_q;

endmodule

// File: tb/tb_cmul_seq_ctrl.sv
// Directed bench for cmul_seq_ctrl; the shared multiplier is modelled inline.
module tb_cmul_seq_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] ar = '0, ai = '0, br = '0, bi = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] mul_a, mul_b;
  logic [2*W-1:0] mul_p;
  logic [2*W:0] re, im;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] ar, ai, br, bi;
    logic [8:0] re, im;
  } vec_t;

  vec_t vecs[5];

  assign mul_p = 8'(mul_a) * 8'(mul_b);

  always #5 clk = ~clk;

  cmul_seq_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .re(re), .im(im), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive_ops(input vec_t v);
    ar = v.ar; ai = v.ai; br = v.br; bi = v.bi;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the
  // output handshake.
  task automatic do_vec(input vec_t v);
    chk("idle_in_ready", 32'(in_ready), 1);
    drive_ops(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ar = 4'($urandom); ai = 4'($urandom); br = 4'($urandom); bi = 4'($urandom);
    chk("mul_ac", 32'({mul_a, mul_b}), 32'({v.ar, v.br}));
    chk("busy_run", 32'(busy), 1);
    @(negedge clk);
    chk("mul_bd", 32'({mul_a, mul_b}), 32'({v.ai, v.bi}));
    @(negedge clk);
    chk("mul_ad", 32'({mul_a, mul_b}), 32'({v.ar, v.bi}));
    @(negedge clk);
    chk("mul_bc", 32'({mul_a, mul_b}), 32'({v.ai, v.br}));
    chk("lat_early", 32'(out_valid), 0);
    @(negedge clk);
    // fifth edge counting the accept edge itself
    chk("lat_valid", 32'(out_valid), 1);
    chk("re", 32'(re), 32'(v.re));
    chk("im", 32'(im), 32'(v.im));
    chk("done_in_ready", 32'(in_ready), 0);
    chk("done_mul", 32'({mul_a, mul_b}), 0);
    @(negedge clk);
    chk("post_valid", 32'(out_valid), 0);
    chk("post_in_ready", 32'(in_ready), 1);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    vec_t bp_a, bp_b;
    int acc_cyc[3];
    int nacc, nres, nov;
    bit pend;
    logic [8:0] hre, him;

    vecs[0] = '{ar: 4'd3,  ai: 4'd5,  br: 4'd7,  bi: 4'd2,  re: 9'd11,   im: 9'd41};
    vecs[1] = '{ar: 4'd15, ai: 4'd15, br: 4'd15, bi: 4'd15, re: 9'd0,    im: 9'h1C2};
    vecs[2] = '{ar: 4'd0,  ai: 4'd15, br: 4'd0,  bi: 4'd15, re: 9'h11F,  im: 9'd0};
    vecs[3] = '{ar: 4'd15, ai: 4'd0,  br: 4'd15, bi: 4'd0,  re: 9'h0E1,  im: 9'd0};
    vecs[4] = '{ar: 4'd2,  ai: 4'd1,  br: 4'd4,  bi: 4'd3,  re: 9'd5,    im: 9'd10};
    bp_a    = '{ar: 4'd9,  ai: 4'd4,  br: 4'd3,  bi: 4'd8,  re: 9'h1FB,  im: 9'd84};
    bp_b    = '{ar: 4'd6,  ai: 4'd1,  br: 4'd2,  bi: 4'd9,  re: 9'd3,    im: 9'd56};

    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_re", 32'(re), 0);
    chk("rst_im", 32'(im), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) do_vec(vecs[i]);

    // Backpressure: hold DONE with new operands pending on the input.
    out_ready = 1'b0;
    drive_ops(bp_a);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_valid0", 32'(out_valid), 1);
    drive_ops(bp_b);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_re", 32'(re), 32'(bp_a.re));
      chk("bp_im", 32'(im), 32'(bp_a.im));
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 32'(in_ready), 1);
    chk("bp_release_valid", 32'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_new_mul_ac", 32'({mul_a, mul_b}), 32'({bp_b.ar, bp_b.br}));
    repeat (4) @(negedge clk);
    chk("bp_new_valid", 32'(out_valid), 1);
    chk("bp_new_re", 32'(re), 32'(bp_b.re));
    chk("bp_new_im", 32'(im), 32'(bp_b.im));
    @(negedge clk);

    // Reset while in M_BD.
    drive_ops(vecs[0]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_mul_bd", 32'({mul_a, mul_b}), 32'({vecs[0].ai, vecs[0].bi}));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_re", 32'(re), 0);
    chk("mid_rst_im", 32'(im), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_vec(vecs[4]);

    // Back-to-back with in_valid and out_ready held high.
    nacc = 0; nres = 0; nov = 0; pend = 1'b0;
    drive_ops(vecs[0]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (out_valid) begin
        nov++;
        if (nres < 3) begin
          hre = (nres == 0) ? vecs[0].re : (nres == 1) ? vecs[1].re : vecs[4].re;
          him = (nres == 0) ? vecs[0].im : (nres == 1) ? vecs[1].im : vecs[4].im;
          chk("b2b_re", 32'(re), 32'(hre));
          chk("b2b_im", 32'(im), 32'(him));
        end
        nres++;
      end
      if (pend) begin
        pend = 1'b0;
        if (nacc == 1) drive_ops(vecs[1]);
        else if (nacc == 2) drive_ops(vecs[4]);
        else in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (nacc < 3) acc_cyc[nacc] = cyc;
        nacc++;
        pend = 1'b1;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", 32'(nacc), 3);
    chk("b2b_valid_cycles", 32'(nov), 3);
    if (nacc >= 3) begin
      chk("b2b_ii_1", 32'(acc_cyc[1] - acc_cyc[0]), 6);
      chk("b2b_ii_2", 32'(acc_cyc[2] - acc_cyc[1]), 6);
    end else begin
      chk("b2b_ii_missing", 32'(nacc), 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
